// File: rtl/adc_dual_frame_reader.sv
// adc_dual_frame_reader: SPI master that reads two back-to-back ADC conversions per
// chip-select frame and presents them as registered parallel samples.
module adc_dual_frame_reader #(
  parameter int ADC_WIDTH = 12,
  parameter int LEAD      = 4,
  parameter int GAP       = 5,
  parameter int CLK_DIV   = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 din,
  output logic                 cs,
  output logic                 sck,
  output logic [ADC_WIDTH-1:0] sample_a,
  output logic [ADC_WIDTH-1:0] sample_b,
  output logic                 sample_valid,
  output logic                 sample_mismatch,
  output logic                 busy
);
  localparam int N  = LEAD + ADC_WIDTH + GAP + ADC_WIDTH + 1;
  localparam int CW = $clog2(N);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int HW = $clog2(CS_IDLE + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] A_LO      = CW'(LEAD);
  localparam logic [CW-1:0] A_HI      = CW'(LEAD + ADC_WIDTH - 1);
  localparam logic [CW-1:0] B_LO      = CW'(LEAD + ADC_WIDTH + GAP);
  localparam logic [CW-1:0] B_HI      = CW'(LEAD + 2 * ADC_WIDTH + GAP - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_IDLE - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 ph_q, ph_d;
  logic [ADC_WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [ADC_WIDTH-1:0] sample_a_q, sample_a_d, sample_b_q, sample_b_d;
  logic                 valid_q, valid_d, mismatch_q, mismatch_d;
  logic                 cs_q, cs_d, sck_q, sck_d, busy_q, busy_d;
  logic                 div_end;

  assign div_end = div_q == DIV_LAST;

  // ph_q is the sck phase inside SHIFT: 0 = low half, 1 = high half
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    ph_d       = ph_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sample_a_d = sample_a_q;
    sample_b_d = sample_b_q;
    valid_d    = 1'b0;
    mismatch_d = mismatch_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (en) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          state_d = SHIFT;
          ph_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          ph_d = !ph_q;
          if (!ph_q) begin
            if (cnt_q >= A_LO && cnt_q <= A_HI) a_sr_d = {a_sr_q[ADC_WIDTH-2:0], din};
            if (cnt_q >= B_LO && cnt_q <= B_HI) b_sr_d = {b_sr_q[ADC_WIDTH-2:0], din};
          end else if (cnt_q == CNT_LAST) begin
            state_d    = CS_HOLD;
            hold_d     = '0;
            sample_a_d = a_sr_q;
            sample_b_d = b_sr_q;
            valid_d    = 1'b1;
            mismatch_d = a_sr_q != b_sr_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        if (hold_q == HOLD_LAST) state_d = en ? CS_SETUP : IDLE;
      end
    endcase
    cs_d   = !(state_d == CS_SETUP || state_d == SHIFT);
    sck_d  = !(state_d == SHIFT && !ph_d);
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      ph_q       <= 1'b0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sample_a_q <= '0;
      sample_b_q <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      ph_q       <= ph_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sample_a_q <= sample_a_d;
      sample_b_q <= sample_b_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      busy_q     <= busy_d;
    end
  end

  assign cs              = cs_q;
  assign sck             = sck_q;
  assign sample_a        = sample_a_q;
  assign sample_b        = sample_b_q;
  assign sample_valid    = valid_q;
  assign sample_mismatch = mismatch_q;
  assign busy            = busy_q;
endmodule

// File: tb/tb_adc_dual_frame_reader.sv
// tb_adc_dual_frame_reader: directed frames against a timeline model of the SPI reader.
module tb_adc_dual_frame_reader;
  localparam int W = 12, LEAD = 4, GAP = 5, CD = 2, CSI = 4;
  localparam int N = LEAD + W + GAP + W + 1;
  localparam int F_ACT = CD + 2 * CD * N;
  localparam int PER = F_ACT + CSI;

  typedef struct {logic [W-1:0] a; logic [W-1:0] b; bit f;} pat_t;

  logic clk = 0, rst, en, din;
  logic cs, sck, sample_valid, sample_mismatch, busy;
  logic [W-1:0] sample_a, sample_b;

  adc_dual_frame_reader #(.ADC_WIDTH(W), .LEAD(LEAD), .GAP(GAP), .CLK_DIV(CD), .CS_IDLE(CSI)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .cs(cs), .sck(sck),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
    .sample_mismatch(sample_mismatch), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  pat_t pq[$];
  pat_t cur;
  int k = 0, nfall = 0, csfall = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit fbit(input int j, input pat_t p);
    int jb;
    jb = j - LEAD - W - GAP;
    if (j >= LEAD && j < LEAD + W) return p.a[W-1-(j-LEAD)];
    if (jb >= 0 && jb < W) return p.b[W-1-jb];
    return p.f;
  endfunction

  always @(posedge clk) cyc++;

  // ADC: new frame on cs fall, next bit presented on each sck fall
  always @(negedge cs or negedge sck) begin
    if (sck) begin
      k = 0;
      nfall = 0;
      csfall++;
      if (pq.size() > 0) cur = pq.pop_front();
      else cur = '{a: '0, b: '0, f: 1'b0};
    end else if (!cs) begin
      din = fbit(k, cur);
      k++;
      nfall++;
    end
  end

  // Model: t counts clk cycles since the frame-start edge (1..PER)
  bit act = 0;
  int t = 0;
  logic [W-1:0] ea = '0, eb = '0;
  logic emm = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act = 0; t = 0; ea = '0; eb = '0; emm = 1'b0;
    end else if (!act) begin
      if (en) begin act = 1; t = 1; end
    end else if (t == PER) begin
      if (en) t = 1;
      else begin act = 0; t = 0; end
    end else begin
      t++;
      if (t == F_ACT + 1) begin ea = cur.a; eb = cur.b; emm = cur.a != cur.b; end
    end
  end

  always @(negedge clk) begin
    int s;
    s = t - 1 - CD;
    chk("cs", cs, !(act && t <= F_ACT));
    chk("sck", sck, !(act && s >= 0 && s < 2 * CD * N && (s / CD) % 2 == 0));
    chk("sample_valid", sample_valid, act && t == F_ACT + 1);
    chk("busy", busy, act);
    chk("sample_a", sample_a, ea);
    chk("sample_b", sample_b, eb);
    chk("sample_mismatch", sample_mismatch, emm);
  end

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1; break; end
    end
    chk("valid_timeout", ok, 1);
  endtask

  task automatic wait_k(input int n);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cs && k >= n) begin ok = 1; break; end
    end
    chk("sck_cycle_timeout", ok, 1);
  endtask

  logic [W-1:0] la[5] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'hFFF};
  logic [W-1:0] lb[5] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'h000};
  bit lf[5] = '{0, 0, 1, 0, 1};
  bit lm[5] = '{0, 0, 0, 0, 1};

  initial begin
    int c0, last, cf0, pulses;
    rst = 1; en = 0; din = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 1);
    chk("rst_a", sample_a, 0);
    chk("rst_b", sample_b, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) pq.push_back('{a: la[i], b: lb[i], f: lf[i]});
    pq.push_back('{a: 12'h5A5, b: 12'h5A5, f: 1'b0});
    pq.push_back('{a: 12'h123, b: 12'h456, f: 1'b1});
    pq.push_back('{a: 12'hABC, b: 12'hABC, f: 1'b0});
    c0 = cyc;
    last = 0;
    en = 1;
    for (int i = 0; i < 5; i++) begin
      wait_valid();
      if (i == 0) chk("first_latency", cyc - c0, 139);
      else chk("frame_period", cyc - last, 142);
      last = cyc;
      chk("lit_a", sample_a, la[i]);
      chk("lit_b", sample_b, lb[i]);
      chk("lit_mismatch", sample_mismatch, lm[i]);
      chk("sck_falls", nfall, 34);
    end
    wait_k(10);
    en = 0;
    wait_valid();
    chk("stop_a", sample_a, 12'h5A5);
    chk("stop_b", sample_b, 12'h5A5);
    cf0 = csfall;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("stop_no_cs_fall", csfall - cf0, 0);
    chk("stop_no_valid", pulses, 0);
    chk("stop_idle_busy", busy, 0);
    en = 1;
    wait_k(20);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async_cs", cs, 1);
    chk("async_sck", sck, 1);
    chk("async_a", sample_a, 0);
    chk("async_b", sample_b, 0);
    chk("async_busy", busy, 0);
    chk("async_valid", sample_valid, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    c0 = cyc;
    wait_valid();
    chk("post_rst_latency", cyc - c0, 139);
    chk("post_rst_a", sample_a, 12'hABC);
    chk("post_rst_b", sample_b, 12'hABC);
    chk("post_rst_mismatch", sample_mismatch, 0);
    en = 0;
    repeat (160) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
